// File: rtl/time_set_pkg.sv
// Shared definitions for the time-setting front end: edit states,
// field limits and the common counter width.
package time_set_pkg;

  // Wide enough for the largest timing parameter (timeout, 5e8 cycles).
  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;

endpackage

// File: rtl/time_set_input_btn_debounce.sv
// One push-button conditioner: 2-flop synchroniser, counter debounce,
// single-cycle press pulse on the debounced rising edge and optional
// auto-repeat while the button stays held.
module btn_debounce
  import time_set_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic Raw,
  output logic Level,
  output logic Press
);

  logic             sync0;
  logic             sync1;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] rep_target;
  logic             rep_first;
  logic             rise;

  // The debounced level is about to flip from 0 to 1 on this edge.
  assign rise = sync1 && !Level && (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  // First repeat waits the long delay, later ones use the short rate.
  assign rep_target = rep_first ? CNT_W'(REPEAT_DELAY - 1) : CNT_W'(REPEAT_RATE - 1);

  // Synchronise the raw input and flip the level after a stable run.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync0  <= 1'b0;
      sync1  <= 1'b0;
      Level  <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync0 <= Raw;
      sync1 <= sync0;
      if (sync1 == Level) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        Level  <= sync1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

  // Emit the initial press pulse and, if enabled, timed repeats while held.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Press     <= 1'b0;
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else begin
      Press <= 1'b0;
      if (rise) begin
        Press     <= 1'b1;
        rep_cnt   <= '0;
        rep_first <= 1'b1;
      end else if (REPEAT_EN && Level) begin
        if (rep_cnt == rep_target) begin
          Press     <= 1'b1;
          rep_cnt   <= '0;
          rep_first <= 1'b0;
        end else begin
          rep_cnt <= rep_cnt + CNT_W'(1);
        end
      end else begin
        rep_cnt   <= '0;
        rep_first <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/time_set_input.sv
// Alarm-clock time-setting front end: conditions MODE/UP/DOWN buttons,
// steps hours then minutes, and commits the result with a one-cycle Load.
module time_set_input
  import time_set_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter int unsigned TIMEOUT_CYCLES  = 500000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_MODE,
  input  logic       BTN_UP,
  input  logic       BTN_DOWN,
  input  logic [5:0] Cur_Hour,
  input  logic [5:0] Cur_Min,
  output logic [5:0] Set_Hour,
  output logic [5:0] Set_Min,
  output logic       Load,
  output logic       Editing,
  output logic       Edit_Field
);

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             mode_press;
  logic             up_press;
  logic             down_press;
  // Debounced levels are not needed by the edit logic (press pulses suffice).
  logic [2:0]       levels_unused;

  // Step a field by one with wrap; out-of-range values wrap to 0 going up
  // and to the maximum going down.
  function automatic logic [5:0] step_field(input logic [5:0] v, input logic up,
                                            input logic [5:0] max);
    if (up) begin
      return (v >= max) ? 6'd0 : v + 6'd1;
    end
    return (v == 6'd0 || v > max) ? max : v - 6'd1;
  endfunction

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_EN      (1'b0),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE)
  ) u_mode (
    .CLK  (CLK),
    .RST  (RST),
    .Raw  (BTN_MODE),
    .Level(levels_unused[0]),
    .Press(mode_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_EN      (1'b1),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE)
  ) u_up (
    .CLK  (CLK),
    .RST  (RST),
    .Raw  (BTN_UP),
    .Level(levels_unused[1]),
    .Press(up_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_EN      (1'b1),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE)
  ) u_down (
    .CLK  (CLK),
    .RST  (RST),
    .Raw  (BTN_DOWN),
    .Level(levels_unused[2]),
    .Press(down_press)
  );

  // Edit FSM with working registers, timeout and registered status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      Set_Hour   <= 6'd0;
      Set_Min    <= 6'd0;
      Load       <= 1'b0;
      Editing    <= 1'b0;
      Edit_Field <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      Load <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (mode_press) begin
            state      <= SET_HOUR;
            Set_Hour   <= Cur_Hour;
            Set_Min    <= Cur_Min;
            Editing    <= 1'b1;
            Edit_Field <= 1'b0;
          end
        end
        SET_HOUR, SET_MIN: begin
          if (mode_press) begin
            // MODE takes priority over any UP/DOWN pulse in the same cycle.
            tmo_cnt <= '0;
            if (state == SET_HOUR) begin
              state      <= SET_MIN;
              Edit_Field <= 1'b1;
            end else begin
              state      <= IDLE;
              Editing    <= 1'b0;
              Edit_Field <= 1'b0;
              Load       <= 1'b1;
            end
          end else if (up_press || down_press) begin
            tmo_cnt <= '0;
            // UP and DOWN together cancel out.
            if (up_press != down_press) begin
              if (state == SET_HOUR) begin
                Set_Hour <= step_field(Set_Hour, up_press, HOUR_MAX);
              end else begin
                Set_Min <= step_field(Set_Min, up_press, MIN_MAX);
              end
            end
          end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Abandon the edit silently; working values are kept.
            state      <= IDLE;
            Editing    <= 1'b0;
            Edit_Field <= 1'b0;
            tmo_cnt    <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        default: begin
          state      <= IDLE;
          Editing    <= 1'b0;
          Edit_Field <= 1'b0;
          tmo_cnt    <= '0;
        end
      endcase
    end
  end

endmodule
